demux_1to8_buf: RTL and testbench
=================================

// Module: demux_1to8_buf
// PURPOSE
//   1-to-8 write-steering demultiplexer. The inverse of the datapath 8:1 read mux.
//   Routes one input word, selected by a 3-bit CS, to one of eight output channels.
//   Each channel has a 1-entry holding register with valid/ready handshake.
//   Feeds register/peripheral write ports from a single CPU write bus.
// PARAMETERS
//   width  32  data width of the input and of every output channel
// PORTS
//   clk        in   1         system clock; all state updates on the rising edge
//   rst_n      in   1         asynchronous, active-low reset
//   in_valid   in   1         input word present
//   in_ready   out  1         block can accept the word addressed by CS
//   CS         in   3         destination channel 0..7; stable while in_valid=1
//   din        in   width     input word
//   out_valid  out  8         bit i: channel i holds a word
//   out_ready  in   8         bit i: consumer i takes the word this cycle
//   dout       out  8*width   channel i data at dout[i*width +: width]
//   busy       out  1         OR of out_valid
// BEHAVIOUR
//   - Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
//     While rst_n=0: out_valid=0, dout=0, busy=0.
//   - Accept: acc = in_valid & in_ready.
//   - in_ready = ~out_valid[CS] | out_ready[CS]. This path is combinational.
//     A channel can be refilled in the same cycle it drains.
//   - Drain: channel i drains when out_valid[i] & out_ready[i].
//   - Latency: a word accepted at edge N is visible on dout[CS] with out_valid[CS]=1 after edge N.
//     There is no combinational in->out path.
//   - Per-channel state: EMPTY or FULL.
//     - EMPTY -> FULL on an accept to that channel.
//     - FULL -> EMPTY on a drain with no accept to that channel.
//     - FULL -> FULL on a simultaneous drain and accept; the register is reloaded with the new din.
//   - While out_valid[i]=1, dout slice i holds steady until the drain.
//     Contents after a drain are don't-care; the RTL holds the old value.
//   - Only the channel selected by CS can load in a given cycle. All other channels drain independently.
//   - Backpressure: if channel CS is FULL and not draining, in_ready=0 and the input stalls.
//     Input to other channels is not blocked, because CS selects the channel.
//   - Reset mid-operation: all buffered words are discarded. No partial state survives.
// CONFIGURATION
//   - Macro DEMUX_CNT_EN.
//     - Defined: adds input cnt_sel[2:0] and output cnt_out[15:0].
//     - cnt_out is the number of words channel cnt_sel has delivered (drains).
//     - Each counter is 16 bits, wraps 0xFFFF->0, and resets to 0.
//     - cnt_out is a combinational read of the registered counter.
//   - Undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//   - Shared package/header: localparam NCH=8, SELW=3, CNTW=16; the channel-state encoding EMPTY=0/FULL=1.
//   - Sub-module demux_chan_buf: one channel's holding register plus valid flag (plus counter under the macro).
//     Instantiate it 8x with a generate loop.
//   - Top level: CS decode to a one-hot load vector, the in_ready mux, and the busy OR-reduce.
// TESTING
//   1. Reset: hold rst_n=0 and drive in_valid=1.
//      -> out_valid=8'h00, dout=0, busy=0. Async assert mid-cycle clears at once.
//   2. Single write: CS=5, din=32'hDEADBEEF, out_ready=0.
//      -> next cycle out_valid=8'h20, dout[5]=DEADBEEF, busy=1, in_ready(CS=5)=0.
//   3. Stall/refill: channel 5 FULL. Drive CS=5, din=32'h1234 and out_ready[5]=1 in the same cycle.
//      -> in_ready=1, then out_valid[5] stays 1 and dout[5]=32'h1234.
//   4. Independence: channel 5 FULL and stalled, then CS=2, din=7.
//      -> in_ready=1, out_valid=8'h24, dout[5] unchanged.
//   5. Sweep: write CS=0..7 back-to-back with out_ready=8'hFF, din=CS+1.
//      -> each channel pulses valid for 1 cycle with din=i+1. No stall.
//   6. DEMUX_CNT_EN: perform 3 drains on channel 3, set cnt_sel=3 -> cnt_out=3.
//      Preload the counter to 0xFFFF and drain once -> cnt_out=0.

Source files
------------

// File: rtl/demux_1to8_buf_pkg.sv
// Shared definitions for the 1-to-8 write-steering demultiplexer.
//   NCH  : number of output channels
//   SELW : width of the channel select
//   CNTW : width of the per-channel delivered-word counter (DEMUX_CNT_EN builds)
//   chan_state_e : per-channel holding-register state
package demux_1to8_buf_pkg;

  localparam int unsigned NCH  = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned CNTW = 16;

  typedef enum logic {
    ChEmpty = 1'b0,
    ChFull  = 1'b1
  } chan_state_e;

  // Binary channel select to one-hot channel vector.
  function automatic logic [NCH-1:0] sel_onehot(input logic [SELW-1:0] sel);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One output channel of demux_1to8_buf: a single-entry holding register with a
// valid flag and, when DEMUX_CNT_EN is defined, a wrapping count of delivered words.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write din into this channel this cycle (only asserted when it can accept)
//   ready      : consumer takes the held word this cycle
//   din        : word to load
//   valid      : channel holds a word
//   dout       : held word; steady while valid
//   cnt        : (DEMUX_CNT_EN only) number of drains, 16-bit wrapping
module demux_chan_buf
  import demux_1to8_buf_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ready,
  input  logic [width-1:0] din,
  output logic             valid,
  output logic [width-1:0] dout
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNTW-1:0]  cnt
`endif
);

  chan_state_e      state_q, state_d;
  logic [width-1:0] data_q;
  logic             drain;

  assign drain = (state_q == ChFull) & ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ChEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load wins over a simultaneous drain (refill stays FULL)
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ChFull;
    end else if (drain) begin
      state_d = ChEmpty;
    end
  end

  // Outputs
  always_comb begin
    valid = (state_q == ChFull);
    dout  = data_q;
  end

  // Data is only written on load, so it holds after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux_1to8_buf.sv
// 1-to-8 write-steering demultiplexer. Routes din to the channel chosen by CS;
// each channel buffers one word behind a valid/ready handshake.
// Optional feature macro: DEMUX_CNT_EN (per-channel delivered-word counters).
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input word present
//   in_ready   : channel CS can accept (combinational from CS/out_ready)
//   CS         : destination channel, held stable while in_valid=1
//   din        : input word
//   out_valid  : bit i set when channel i holds a word
//   out_ready  : bit i set when consumer i takes its word
//   dout       : channel i data at dout[i*width +: width]
//   busy       : any channel holds a word
//   cnt_sel    : (DEMUX_CNT_EN) channel whose counter is shown on cnt_out
//   cnt_out    : (DEMUX_CNT_EN) drains delivered by channel cnt_sel
module demux_1to8_buf
  import demux_1to8_buf_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      CS,
  input  logic [width-1:0]     din,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*width-1:0] dout,
  output logic                 busy
`ifdef DEMUX_CNT_EN
  ,
  input  logic [SELW-1:0]      cnt_sel,
  output logic [CNTW-1:0]      cnt_out
`endif
);

  logic           acc;
  logic [NCH-1:0] load_vec;

  // A channel can be refilled in the cycle it drains.
  assign in_ready = ~out_valid[CS] | out_ready[CS];
  assign acc      = in_valid & in_ready;
  assign load_vec = acc ? sel_onehot(CS) : '0;
  assign busy     = |out_valid;

`ifdef DEMUX_CNT_EN
  logic [CNTW-1:0] cnt_arr [NCH];
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    demux_chan_buf #(
      .width (width)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_vec[i]),
      .ready (out_ready[i]),
      .din   (din),
      .valid (out_valid[i]),
      .dout  (dout[i*width +: width])
`ifdef DEMUX_CNT_EN
      ,
      .cnt   (cnt_arr[i])
`endif
    );
  end

`ifdef DEMUX_CNT_EN
  assign cnt_out = cnt_arr[cnt_sel];
`endif

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Self-checking bench for demux_1to8_buf: directed scenarios followed by random
// traffic, all checked against a per-channel occupancy/data model.
module tb_demux_1to8_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   CS;
  logic [W-1:0] din;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [8*W-1:0] dout;
  logic         busy;
`ifdef DEMUX_CNT_EN
  logic [2:0]   cnt_sel;
  logic [15:0]  cnt_out;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: which channels hold a word, what they hold, drains delivered.
  bit           mv [8];
  logic [W-1:0] md [8];
  int           mcnt [8];

  demux_1to8_buf #(
    .width (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .CS        (CS),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic logic [8*W-1:0] m_dout();
    logic [8*W-1:0] d;
    for (int i = 0; i < 8; i++) d[i*W +: W] = md[i];
    return d;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i]   = 1'b0;
      md[i]   = '0;
      mcnt[i] = 0;
    end
  endfunction

  // Called just after a falling edge with inputs already driven: checks the
  // combinational ready, advances one clock, then checks registered outputs.
  task automatic cycle(input string tag);
    bit exp_rdy;
    bit acc;
    #1;
    exp_rdy = !mv[CS] || out_ready[CS];
    acc     = in_valid && exp_rdy;
    check({tag, "_in_ready"}, 256'(in_ready), 256'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (mv[i] && out_ready[i]) begin
        mv[i]   = 1'b0;
        mcnt[i] = (mcnt[i] + 1) % 65536;
      end
    end
    if (acc) begin
      mv[CS] = 1'b1;
      md[CS] = din;
    end
    @(negedge clk);
    check({tag, "_out_valid"}, 256'(out_valid), 256'(m_valid()));
    check({tag, "_dout"}, 256'(dout), 256'(m_dout()));
    check({tag, "_busy"}, 256'(busy), 256'(m_valid() != 8'h00));
`ifdef DEMUX_CNT_EN
    check({tag, "_cnt_out"}, 256'(cnt_out), 256'(mcnt[cnt_sel]));
`endif
  endtask

  initial begin
    bit pending;
    m_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    CS        = 3'd0;
    din       = 32'hFFFF_FFFF;
    out_ready = 8'h00;
`ifdef DEMUX_CNT_EN
    cnt_sel   = 3'd0;
`endif

    // Reset held with a live input: nothing may load.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(8'h00));
    check("rst_dout", 256'(dout), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Single write to channel 5, no consumer.
    CS = 3'd5; din = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 8'h00;
    cycle("single");
    in_valid = 1'b0;
    check("single_valid_const", 256'(out_valid), 256'(8'h20));
    check("single_dout5", 256'(dout[5*W +: W]), 256'(32'hDEADBEEF));
    #1 check("single_stall_rdy", 256'(in_ready), 256'd0);

    // Refill channel 5 in the cycle it drains.
    CS = 3'd5; din = 32'h1234; in_valid = 1'b1; out_ready = 8'h20;
    cycle("refill");
    check("refill_valid5", 256'(out_valid[5]), 256'd1);
    check("refill_dout5", 256'(dout[5*W +: W]), 256'(32'h1234));

    // Channel 5 stalled; channel 2 still accepts.
    CS = 3'd2; din = 32'd7; in_valid = 1'b1; out_ready = 8'h00;
    cycle("indep");
    check("indep_valid_const", 256'(out_valid), 256'(8'h24));
    check("indep_dout5", 256'(dout[5*W +: W]), 256'(32'h1234));

    // Back-to-back sweep with every consumer ready.
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      CS = 3'(i); din = 32'(i + 1); in_valid = 1'b1;
      cycle("sweep");
      check("sweep_onehot", 256'(out_valid), 256'(8'h01 << i));
      check("sweep_data", 256'(dout[i*W +: W]), 256'(i + 1));
    end
    in_valid = 1'b0;
    cycle("sweep_tail");

    // Random traffic, with an asynchronous reset dropped in mid-cycle.
    pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        CS       = 3'($urandom_range(0, 7));
        din      = $urandom;
      end
      out_ready = 8'($urandom);
`ifdef DEMUX_CNT_EN
      cnt_sel   = 3'($urandom_range(0, 7));
`endif
      #1 pending = in_valid && !(!mv[CS] || out_ready[CS]);
      cycle("rand");
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 256'(out_valid), 256'(8'h00));
        check("async_dout", 256'(dout), 256'd0);
        check("async_busy", 256'(busy), 256'd0);
        m_reset();
        pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

`ifdef DEMUX_CNT_EN
    // Counter: three drains on channel 3, then run it up to the wrap.
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    CS = 3'd3; din = 32'hC0FFEE; in_valid = 1'b1; out_ready = 8'h08; cnt_sel = 3'd3;
    for (int i = 0; i < 4; i++) cycle("cnt");
    check("cnt_three", 256'(cnt_out), 256'(16'd3));
    repeat (65532) @(posedge clk);
    mcnt[3] = (mcnt[3] + 65532) % 65536;
    @(negedge clk);
    check("cnt_ffff", 256'(cnt_out), 256'(16'hFFFF));
    cycle("cnt_wrap");
    check("cnt_wrap_zero", 256'(cnt_out), 256'(16'h0000));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
